// File: rtl/conv_encode_r4.sv
// Radix-4, rate-1/2, K=3 convolutional encoder (generators 7/5 octal).
// Each accepted beat carries two information bits and yields four coded
// bits. After FRAME_SYMS symbols a zero-tail step returns the trellis to
// state 0, so the receiving Viterbi traceback sees a zero start and end state.
module conv_encode_r4 #(
  parameter int FRAME_SYMS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [1:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic [3:0] o_code,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int CW = $clog2(FRAME_SYMS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_SYMS - 1);

  typedef enum logic {
    ENC   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [3:0]      code_q, code_d;
  logic            last_q, last_d;

  logic            slotFree;
  logic            accept;
  logic [1:0]      stepSym;
  logic [1:0]      stepNext;
  logic [3:0]      stepCode;

  // One radix-4 trellis step: bit [1] is encoded first from state s, then
  // bit [0] from the intermediate state {sym[1], s[1]}.
  // Result is {next_state[1:0], c0(bit1), c1(bit1), c0(bit0), c1(bit0)}.
  function automatic logic [5:0] encStep(input logic [1:0] s, input logic [1:0] sym);
    logic a;
    logic b;
    a = sym[1];
    b = sym[0];
    return {b, a, a ^ s[1] ^ s[0], a ^ s[0], b ^ a ^ s[1], b ^ s[1]};
  endfunction

  // The output slot can take a new beat when it is empty or being drained now.
  assign slotFree = !valid_q || i_ready;
  assign o_ready  = !rst && (state_q == ENC) && slotFree;
  assign accept   = i_valid && o_ready;

  // The tail step encodes a 00 symbol, so the step input is forced in FLUSH.
  assign stepSym  = (state_q == FLUSH) ? 2'b00 : i_data;
  assign {stepNext, stepCode} = encStep(s_q, stepSym);

  assign o_valid = valid_q;
  assign o_code  = code_q;
  assign o_last  = last_q;

  // Next-state logic: encode accepted symbols in ENC, emit the zero tail in FLUSH.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !i_ready;
    code_d  = code_q;
    last_d  = last_q;
    case (state_q)
      ENC: begin
        if (accept) begin
          valid_d = 1'b1;
          code_d  = stepCode;
          last_d  = 1'b0;
          s_d     = stepNext;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slotFree) begin
          valid_d = 1'b1;
          code_d  = stepCode;
          last_d  = 1'b1;
          s_d     = 2'b00;
          cnt_d   = '0;
          state_d = ENC;
        end
      end
      default: begin
        state_d = ENC;
      end
    endcase
  end

  // State, trellis and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENC;
      s_q     <= 2'b00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= 4'b0000;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      last_q  <= last_d;
    end
  end

endmodule
